// File: rtl/mrd_mem_pkg.sv
// mrd_mem_pkg: shared mode encoding, default geometry and sample type
// for the banked butterfly memory.
package mrd_mem_pkg;

  typedef enum logic [1:0] {
    SINK    = 2'b00,
    COMPUTE = 2'b01,
    SOURCE  = 2'b10,
    HOLD    = 2'b11
  } mode_e;

  localparam int NB_DEF    = 7;
  localparam int DEPTH_DEF = 256;
  localparam int DW_DEF    = 18;
  localparam int NP_DEF    = 5;
  localparam int AW_DEF    = 12;

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

endpackage

// File: rtl/mrd_banked_mem_if.sv
// mrd_banked_mem_if: load, butterfly and drain ports of the banked
// memory; master drives requests, slave is the memory.
interface mrd_banked_mem_if
  import mrd_mem_pkg::*;
#(
  parameter int NP = NP_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  mode_e                  mode;
  logic                   sink_valid;
  logic [AW-1:0]          sink_addr;
  logic signed [DW-1:0]   sink_re;
  logic signed [DW-1:0]   sink_im;
  logic                   rd_valid;
  logic [NP*AW-1:0]       rd_addr;
  logic                   rd_out_valid;
  logic [NP*DW-1:0]       rd_re;
  logic [NP*DW-1:0]       rd_im;
  logic                   wb_valid;
  logic [NP*AW-1:0]       wb_addr;
  logic [NP*DW-1:0]       wb_re;
  logic [NP*DW-1:0]       wb_im;
  logic                   src_req;
  logic [AW-1:0]          src_addr;
  logic                   src_valid;
  logic signed [DW-1:0]   src_re;
  logic signed [DW-1:0]   src_im;
  logic                   busy;
  logic                   conflict_err;

  modport master (
    output mode, sink_valid, sink_addr, sink_re, sink_im,
    output rd_valid, rd_addr, wb_valid, wb_addr, wb_re, wb_im,
    output src_req, src_addr,
    input  rd_out_valid, rd_re, rd_im,
    input  src_valid, src_re, src_im, busy, conflict_err
  );

  modport slave (
    input  mode, sink_valid, sink_addr, sink_re, sink_im,
    input  rd_valid, rd_addr, wb_valid, wb_addr, wb_re, wb_im,
    input  src_req, src_addr,
    output rd_out_valid, rd_re, rd_im,
    output src_valid, src_re, src_im, busy, conflict_err
  );
endinterface

// File: rtl/mrd_addr_split.sv
// mrd_addr_split: linear address to bank (mod NB) / row (div NB),
// plus an in-range flag for addresses below NB*DEPTH.
module mrd_addr_split #(
  parameter int NB    = 7,
  parameter int DEPTH = 256,
  parameter int AW    = 12,
  parameter int BW    = $clog2(NB),
  parameter int RW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr_i,
  output logic [BW-1:0] bank_o,
  output logic [RW-1:0] row_o,
  output logic          inr_o
);
  localparam int unsigned LIM = NB * DEPTH;

  assign bank_o = BW'(32'(addr_i) % NB);
  assign row_o  = RW'(32'(addr_i) / NB);
  assign inr_o  = 32'(addr_i) < LIM;
endmodule

// File: rtl/mrd_banked_mem_ram.sv
// mrd_banked_mem_ram: simple dual-port bank, read-first, one-cycle
// registered read; contents are never reset.
module mrd_banked_mem_ram #(
  parameter int DEPTH = 256,
  parameter int W     = 36,
  parameter int RW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [RW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [RW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mrd_banked_mem.sv
// mrd_banked_mem: NB-bank complex sample memory with NP-lane butterfly
// ports; MRD_MEM_CONFLICT_CHK_EN adds a sticky conflict flag/counter.
module mrd_banked_mem
  import mrd_mem_pkg::*;
#(
  parameter int NB    = NB_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF,
  parameter int NP    = NP_DEF,
  parameter int AW    = AW_DEF
) (
  input logic clk,
  input logic rst_n,
  mrd_banked_mem_if.slave bus
);
  localparam int BW = $clog2(NB);
  localparam int RW = $clog2(DEPTH);

  typedef struct packed {
    logic          v;
    logic [BW-1:0] bank;
    logic [RW-1:0] row;
  } lane_t;

  typedef struct packed {
    logic          v;
    logic [BW-1:0] bank;
  } sel_t;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } smp_t;

  logic [NP-1:0][AW-1:0] ra, wa;
  logic [NP-1:0]         rv, wv, rin, win, rcol, wcol;
  logic [NP-1:0][BW-1:0] rbk, wbk;
  logic [NP-1:0][RW-1:0] rrw, wrw;
  smp_t  [NP-1:0]        wd, lo;
  lane_t [NP-1:0]        rl, wl;
  logic                  rreq, rsrc, bsy;

  lane_t [NP-1:0] r1_q, w1_q, w2_q;
  sel_t  [NP-1:0] r2_q;
  smp_t  [NP-1:0] w1d_q, w2d_q;
  logic           r1v_q, r2v_q, r1s_q, r2s_q;

  logic [NB-1:0]         ren, wen;
  logic [NB-1:0][RW-1:0] raddr, waddr;
  smp_t [NB-1:0]         wdat, rdat;

  // Single-lane ports borrow lane 0 of the butterfly datapath.
  always_comb begin
    ra   = bus.rd_addr;
    wa   = bus.wb_addr;
    rv   = '0;
    wv   = '0;
    rsrc = 1'b0;
    for (int i = 0; i < NP; i++) begin
      wd[i] = '{re: bus.wb_re[i*DW +: DW], im: bus.wb_im[i*DW +: DW]};
    end
    unique case (bus.mode)
      SINK: begin
        wa[0] = bus.sink_addr;
        wv[0] = bus.sink_valid;
        wd[0] = '{re: bus.sink_re, im: bus.sink_im};
      end
      COMPUTE: begin
        rv = {NP{bus.rd_valid}};
        wv = {NP{bus.wb_valid}};
      end
      SOURCE: begin
        ra[0] = bus.src_addr;
        rv[0] = bus.src_req;
        rsrc  = 1'b1;
      end
      default: ;
    endcase
  end

  assign rreq = rv[0];

  for (genvar i = 0; i < NP; i++) begin : g_split
    mrd_addr_split #(.NB(NB), .DEPTH(DEPTH), .AW(AW)) u_rs (
      .addr_i(ra[i]), .bank_o(rbk[i]), .row_o(rrw[i]), .inr_o(rin[i])
    );
    mrd_addr_split #(.NB(NB), .DEPTH(DEPTH), .AW(AW)) u_ws (
      .addr_i(wa[i]), .bank_o(wbk[i]), .row_o(wrw[i]), .inr_o(win[i])
    );
  end

  // Lowest lane wins a bank; bank equality is transitive, so raw
  // validity of earlier lanes is enough to find every loser.
  always_comb begin
    rcol = '0;
    wcol = '0;
    for (int j = 1; j < NP; j++) begin
      for (int i = 0; i < j; i++) begin
        if (rv[i] && rin[i] && rv[j] && rin[j] && rbk[i] == rbk[j])
          rcol[j] = 1'b1;
        if (wv[i] && win[i] && wv[j] && win[j] && wbk[i] == wbk[j])
          wcol[j] = 1'b1;
      end
    end
    for (int i = 0; i < NP; i++) begin
      rl[i] = '{v: rv[i] & rin[i] & ~rcol[i], bank: rbk[i], row: rrw[i]};
      wl[i] = '{v: wv[i] & win[i] & ~wcol[i], bank: wbk[i], row: wrw[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_q  <= '0;
      r2_q  <= '0;
      w1_q  <= '0;
      w2_q  <= '0;
      r1v_q <= 1'b0;
      r2v_q <= 1'b0;
      r1s_q <= 1'b0;
      r2s_q <= 1'b0;
    end else begin
      r1_q  <= rl;
      w1_q  <= wl;
      w2_q  <= w1_q;
      r1v_q <= rreq;
      r1s_q <= rsrc;
      r2v_q <= r1v_q;
      r2s_q <= r1s_q;
      for (int i = 0; i < NP; i++) begin
        r2_q[i] <= '{v: r1_q[i].v, bank: r1_q[i].bank};
      end
    end
  end

  always_ff @(posedge clk) begin
    w1d_q <= wd;
    w2d_q <= w1d_q;
  end

  // Writes land one edge after same-age reads sample the RAM, giving
  // read-old for requests up to one cycle behind a write.
  always_comb begin
    ren   = '0;
    wen   = '0;
    raddr = '0;
    waddr = '0;
    wdat  = '0;
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < NP; i++) begin
        if (r1_q[i].v && r1_q[i].bank == BW'(b)) begin
          ren[b]   = 1'b1;
          raddr[b] = r1_q[i].row;
        end
        if (w2_q[i].v && w2_q[i].bank == BW'(b)) begin
          wen[b]   = rst_n;
          waddr[b] = w2_q[i].row;
          wdat[b]  = w2d_q[i];
        end
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    mrd_banked_mem_ram #(.DEPTH(DEPTH), .W(2*DW)) u_ram (
      .clk    (clk),
      .we_i   (wen[b]),
      .waddr_i(waddr[b]),
      .wdata_i(wdat[b]),
      .re_i   (ren[b]),
      .raddr_i(raddr[b]),
      .rdata_o(rdat[b])
    );
  end

  always_comb begin
    bus.rd_re  = '0;
    bus.rd_im  = '0;
    bus.src_re = '0;
    bus.src_im = '0;
    for (int i = 0; i < NP; i++) begin
      lo[i] = '0;
      for (int b = 0; b < NB; b++) begin
        if (r2_q[i].v && r2_q[i].bank == BW'(b)) lo[i] = rdat[b];
      end
      if (!r2s_q) begin
        bus.rd_re[i*DW +: DW] = lo[i].re;
        bus.rd_im[i*DW +: DW] = lo[i].im;
      end
    end
    if (r2s_q) begin
      bus.src_re = lo[0].re;
      bus.src_im = lo[0].im;
    end
  end

  always_comb begin
    bsy = r1v_q | r2v_q;
    for (int i = 0; i < NP; i++) bsy |= w1_q[i].v | w2_q[i].v;
  end

  assign bus.rd_out_valid = r2v_q & ~r2s_q;
  assign bus.src_valid    = r2v_q & r2s_q;
  assign bus.busy         = bsy;

`ifdef MRD_MEM_CONFLICT_CHK_EN
  // Saturating count never wraps, so non-zero doubles as the sticky flag.
  logic [15:0] ccnt_q;
  logic        conf;

  assign conf = |rcol | |wcol;

  always_ff @(posedge clk) begin
    if (!rst_n) ccnt_q <= '0;
    else if (conf && ccnt_q != 16'hFFFF) ccnt_q <= ccnt_q + 16'd1;
  end

  assign bus.conflict_err = |ccnt_q;
`else
  assign bus.conflict_err = 1'b0;
`endif
endmodule

// File: tb/tb_mrd_banked_mem.sv
// tb_mrd_banked_mem: directed vectors for the banked butterfly memory;
// conflict_err is expected only with MRD_MEM_CONFLICT_CHK_EN defined.
module tb_mrd_banked_mem;
  import mrd_mem_pkg::*;

  localparam int NB    = NB_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int DW    = DW_DEF;
  localparam int NP    = NP_DEF;
  localparam int AW    = AW_DEF;
  localparam int TOP   = NB * DEPTH;
`ifdef MRD_MEM_CONFLICT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [NP*AW-1:0] av_t;
  typedef logic [NP*DW-1:0] dv_t;
  typedef struct {
    av_t a;
    dv_t re;
    bit  conf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   err_exp = 1'b0;
  vec_t tv[7];
  cplx_t s;

  always #5 clk = ~clk;

  mrd_banked_mem_if #(.NP(NP), .AW(AW), .DW(DW)) bus ();

  mrd_banked_mem #(
    .NB(NB), .DEPTH(DEPTH), .DW(DW), .NP(NP), .AW(AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic av_t pa(input int a0, a1, a2, a3, a4);
    return {AW'(a4), AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic dv_t pd(input int d0, d1, d2, d3, d4);
    return {DW'(d4), DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  function automatic dv_t ng(input dv_t r);
    dv_t o;
    for (int i = 0; i < NP; i++) o[i*DW +: DW] = DW'(0) - r[i*DW +: DW];
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.mode       = HOLD;
    bus.sink_valid = 1'b0;
    bus.sink_addr  = '0;
    bus.sink_re    = '0;
    bus.sink_im    = '0;
    bus.rd_valid   = 1'b0;
    bus.rd_addr    = '0;
    bus.wb_valid   = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_re      = '0;
    bus.wb_im      = '0;
    bus.src_req    = 1'b0;
    bus.src_addr   = '0;
  endtask

  task automatic rd_chk(input string nm, input av_t a, input dv_t er);
    bus.rd_valid = 1'b1;
    bus.rd_addr  = a;
    step();
    bus.rd_valid = 1'b0;
    chk({nm, "/early"}, bus.rd_out_valid, 0);
    chk({nm, "/busy"}, bus.busy, 1);
    step();
    chk({nm, "/v"}, bus.rd_out_valid, 1);
    chk({nm, "/re"}, bus.rd_re, er);
    chk({nm, "/im"}, bus.rd_im, ng(er));
  endtask

  initial begin
    tv[0] = '{pa(0, 1, 2, 3, 4), pd(0, 1, 2, 3, 4), 1'b0};
    tv[1] = '{pa(100, 101, 102, 103, 104), pd(100, 101, 102, 103, 104), 1'b0};
    tv[2] = '{pa(20, 21, 22, 23, 24), pd(20, 21, 22, 23, 24), 1'b0};
    tv[3] = '{pa(50, 51, 52, 53, 54), pd(50, 51, 52, 53, 54), 1'b0};
    tv[4] = '{pa(0, 7, 1, 2, 3), pd(0, 0, 1, 2, 3), 1'b1};
    tv[5] = '{pa(1791, 1792, 5, 6, 1790), pd(1791, 0, 5, 0, 0), 1'b1};
    tv[6] = '{pa(4095, 35, 36, 8, 9), pd(0, 35, 36, 0, 9), 1'b1};

    rst_n = 1'b0;
    idle();
    step();
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_rov", bus.rd_out_valid, 0);
    chk("rst_srcv", bus.src_valid, 0);
    chk("rst_err", bus.conflict_err, 0);
    chk("rst_rd_re", bus.rd_re, 0);
    chk("rst_src_re", bus.src_re, 0);
    rst_n = 1'b1;
    step();

    bus.mode = SINK;
    for (int a = 0; a < TOP; a++) begin
      s = '{re: DW'(a), im: DW'(-a)};
      bus.sink_valid = 1'b1;
      bus.sink_addr  = AW'(a);
      bus.sink_re    = s.re;
      bus.sink_im    = s.im;
      step();
    end

    // out-of-range sink, with butterfly traffic that SINK must drop
    bus.sink_addr = AW'(TOP);
    bus.sink_re   = DW'(999);
    bus.sink_im   = DW'(999);
    bus.rd_valid  = 1'b1;
    bus.rd_addr   = pa(1, 2, 3, 4, 5);
    bus.wb_valid  = 1'b1;
    bus.wb_addr   = pa(50, 51, 52, 53, 54);
    bus.wb_re     = pd(7, 7, 7, 7, 7);
    bus.wb_im     = pd(7, 7, 7, 7, 7);
    step();
    idle();
    bus.mode = SINK;
    step();
    chk("sink_drop_rd", bus.rd_out_valid, 0);
    step();
    step();

    bus.mode = COMPUTE;
    for (int k = 0; k < 7; k++) begin
      rd_chk($sformatf("vec%0d", k), tv[k].a, tv[k].re);
      err_exp = err_exp | (tv[k].conf & CHK);
      chk($sformatf("vec%0d/err", k), bus.conflict_err, err_exp);
    end
    step();

    // wb with reads at +0, +1, +2 cycles: old, old, new
    bus.wb_valid = 1'b1;
    bus.wb_addr  = pa(10, 11, 12, 13, 14);
    bus.wb_re    = pd(100, 101, 102, 103, 104);
    bus.wb_im    = ng(pd(100, 101, 102, 103, 104));
    bus.rd_valid = 1'b1;
    bus.rd_addr  = pa(10, 11, 12, 13, 14);
    step();
    bus.wb_valid = 1'b0;
    step();
    chk("raw0/v", bus.rd_out_valid, 1);
    chk("raw0/re", bus.rd_re, pd(10, 11, 12, 13, 14));
    step();
    bus.rd_valid = 1'b0;
    chk("raw1/v", bus.rd_out_valid, 1);
    chk("raw1/re", bus.rd_re, pd(10, 11, 12, 13, 14));
    step();
    chk("raw2/v", bus.rd_out_valid, 1);
    chk("raw2/re", bus.rd_re, pd(100, 101, 102, 103, 104));
    chk("raw2/im", bus.rd_im, ng(pd(100, 101, 102, 103, 104)));
    step();
    chk("raw_pulse", bus.rd_out_valid, 0);

    // read survives a switch to HOLD; wb in HOLD is dropped
    bus.rd_valid = 1'b1;
    bus.rd_addr  = pa(30, 31, 32, 33, 34);
    step();
    bus.mode     = HOLD;
    bus.rd_valid = 1'b0;
    bus.wb_valid = 1'b1;
    bus.wb_addr  = pa(30, 31, 32, 33, 34);
    bus.wb_re    = pd(7, 7, 7, 7, 7);
    step();
    bus.wb_valid = 1'b0;
    chk("hold/v", bus.rd_out_valid, 1);
    chk("hold/re", bus.rd_re, pd(30, 31, 32, 33, 34));
    step();
    step();
    bus.mode = COMPUTE;
    rd_chk("hold_wb", pa(30, 31, 32, 33, 34), pd(30, 31, 32, 33, 34));

    // drain port, back to back
    bus.mode     = SOURCE;
    bus.src_req  = 1'b1;
    bus.src_addr = AW'(500);
    step();
    bus.src_addr = AW'(501);
    step();
    bus.src_addr = AW'(4095);
    chk("src0/v", bus.src_valid, 1);
    chk("src0/re", bus.src_re, DW'(500));
    chk("src0/im", bus.src_im, DW'(-500));
    chk("src0/rov", bus.rd_out_valid, 0);
    step();
    bus.src_req = 1'b0;
    chk("src1/v", bus.src_valid, 1);
    chk("src1/re", bus.src_re, DW'(501));
    step();
    chk("src_oor/v", bus.src_valid, 1);
    chk("src_oor/re", bus.src_re, 0);
    step();
    chk("src_pulse", bus.src_valid, 0);

    bus.mode     = COMPUTE;
    bus.src_req  = 1'b1;
    bus.src_addr = AW'(500);
    step();
    bus.src_req = 1'b0;
    step();
    chk("src_drop", bus.src_valid, 0);

    // reset while a wb sits in the last stage before the RAM
    bus.wb_valid = 1'b1;
    bus.wb_addr  = pa(40, 41, 42, 43, 44);
    bus.wb_re    = pd(555, 556, 557, 558, 559);
    bus.wb_im    = pd(555, 556, 557, 558, 559);
    step();
    bus.wb_valid = 1'b0;
    step();
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    step();
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_err", bus.conflict_err, 0);
    chk("post_rst_rov", bus.rd_out_valid, 0);
    rst_n = 1'b1;
    step();
    rd_chk("rst_keep", pa(40, 41, 42, 43, 44), pd(40, 41, 42, 43, 44));
    step();
    chk("final_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mrd_banked_mem.md
MRD_BANKED_MEM -- requirements
Module: mrd_banked_mem

Interface
REQ-001 SHALL have parameter NB, default 7: number of memory banks, prime, 2..7.
REQ-002 SHALL have parameter DEPTH, default 256: words per bank, power of two.
REQ-003 SHALL have parameter DW, default 18: signed width of each real/imag component.
REQ-004 SHALL have parameter NP, default 5: butterfly lanes per read/write-back port, 1..NB.
REQ-005 SHALL have parameter AW, default 12: linear address width, with 2^AW >= NB*DEPTH.
REQ-006 clk  in  1  clock.
REQ-007 rst_n  in  1  reset; synchronous, active-low; clock clk.
REQ-008 mode  in  2  00 SINK, 01 COMPUTE, 10 SOURCE, 11 HOLD.
REQ-009 sink_valid, sink_addr, sink_re, sink_im  in  1/AW/DW/DW  single-lane load port.
REQ-010 rd_valid, rd_addr  in  1/NP*AW  butterfly read request.
REQ-011 rd_out_valid, rd_re, rd_im  out  1/NP*DW/NP*DW  butterfly read data, lane-ordered.
REQ-012 wb_valid, wb_addr, wb_re, wb_im  in  1/NP*AW/NP*DW/NP*DW  butterfly write-back.
REQ-013 src_req, src_addr  in  1/AW  single-lane drain request.
REQ-014 src_valid, src_re, src_im  out  1/DW/DW  drain data.
REQ-015 busy  out  1  any read or write in flight.
REQ-016 conflict_err  out  1  sticky bank-conflict flag.

Function
REQ-017 Every address SHALL map to bank = addr mod NB, row = addr div NB; row truncated to log2(DEPTH) bits.
REQ-018 Addresses >= NB*DEPTH SHALL be ignored on writes; on reads, that lane returns zero.
REQ-019 sink_valid SHALL be accepted only in SINK. Write is registered once; the RAM updates at edge t+2 for an input at edge t.
REQ-020 wb_valid SHALL be accepted only in COMPUTE. All NP lanes write in the same cycle with the same 2-edge latency as sink.
REQ-021 rd_valid SHALL be accepted only in COMPUTE. rd_out_valid and data appear exactly 2 cycles after the request: address-register stage, then RAM read stage. The output mux is selected by the bank index delayed 2 cycles.
REQ-022 src_req SHALL be accepted only in SOURCE, with the same 2-cycle latency as reads; the result appears on src_valid/src_re/src_im.
REQ-023 Requests presented in a non-matching mode, or in HOLD, SHALL be dropped silently.
REQ-024 A read issued at edge t+2 or later SHALL observe a write issued at t. Same-cycle read/write to the same location SHALL return the old data.
REQ-025 Bank conflict: two or more valid lanes in one cycle targeting the same bank. The lowest-numbered lane SHALL win; other colliding lanes are dropped (write) or return zero (read).
REQ-026 A mode change SHALL NOT cancel operations already accepted; they complete with their normal latency.
REQ-027 busy SHALL be high while any pipeline stage holds a valid write, read or drain.
REQ-028 rd_out_valid and src_valid SHALL be single-cycle pulses, one per accepted request, with back-to-back throughput of 1 per cycle.

Reset
REQ-029 While rst_n=0, all pipeline valids, rd_out_valid, src_valid, busy and conflict_err SHALL be 0 at the next edge. Data outputs SHALL be 0.
REQ-030 RAM contents SHALL NOT be cleared by reset. Operations in flight when reset asserts SHALL be discarded, with no write completing.

Configuration
REQ-031 With MRD_MEM_CONFLICT_CHK_EN defined, conflict_err SHALL set on any conflict per REQ-025 and stay set until reset. An internal 16-bit saturating conflict counter SHALL also be kept.
REQ-032 Without MRD_MEM_CONFLICT_CHK_EN, conflict_err SHALL be tied 0 and no counter is built; lane-priority resolution is unchanged.

Structure
REQ-033 Package mrd_mem_pkg SHALL hold the mode enum (SINK/COMPUTE/SOURCE/HOLD), the default NB/DEPTH/DW/NP/AW constants, and a complex-sample struct {re, im}.
REQ-034 The address split SHALL be one sub-module, mrd_addr_split (combinational div/mod by NB), instantiated per lane.
REQ-035 Banks SHALL be NB instances of a simple dual-port RAM with 1-cycle read latency.

Verification
REQ-036 SINK: write addresses 0..NB*DEPTH-1 with data = address. Then COMPUTE: read lanes {0,7,14,21,28} -> these are 5 distinct banks only when NB is not 7 (for NB=7 they collide). Use {0,1,2,3,4} instead -> rd_re = {0,1,2,3,4}, exactly 2 cycles later.
REQ-037 COMPUTE: wb to {10,11,12,13,14} with data 100..104, then read the same addresses 2 cycles later -> 100..104. A read issued 1 cycle after the wb returns the old values 10..14.
REQ-038 Conflict: rd_addr={0,7,1,2,3} with NB=7 -> lane0=0, lane1=0 (dropped), conflict_err=1 when the macro is defined and 0 otherwise.
REQ-039 Out-of-range: sink write to addr NB*DEPTH -> no bank changes. A read of that address returns 0.
REQ-040 Mode/reset: issue a read, switch to HOLD next cycle -> data still delivered. Assert rst_n during an in-flight wb -> the target keeps its old value, and busy=0 one cycle after reset.
